// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage and the data memory.
// Single outstanding request: the master raises dmem_req and holds
// dmem_we/addr/wstrb/wdata stable until the slave answers with dmem_ack.
// dmem_rdata is valid in the same cycle as dmem_ack.
//   master (stage side): drives req/we/addr/wstrb/wdata, samples ack/rdata
//   slave  (memory side): samples req/we/addr/wstrb/wdata, drives ack/rdata
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 5-stage pipeline (EX/MEM -> MEM/WB).
// Issues loads/stores on a single-outstanding req/ack bus, stalls the
// upstream pipeline until the access completes, extracts and extends
// byte/half load data, and drives the registered MEM/WB signals.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ex_*              EX/MEM slot contents (held stable while mem_stall = 1)
//   dmem              data-memory bus (master side)
//   mem_stall         combinational stall request to earlier stages
//   mem_misalign      registered one-cycle misaligned-access pulse
//   mem_*             MEM/WB pipeline registers
// Parameter MISALIGN_TRAP: 1 drops and flags misaligned accesses,
// 0 forces the address to alignment and performs the access.
module mem_access_stage #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  input  logic [31:0]                ex_alu_res,
  input  logic [31:0]                ex_store_data,
  input  logic                       ex_mem_rd_en,
  input  logic                       ex_mem_wr_en,
  input  logic [1:0]                 ex_mem_size,
  input  logic                       ex_mem_unsigned,
  input  logic                       ex_wb_sel,
  input  logic                       ex_wb_en,
  input  logic [4:0]                 ex_rd,
  mem_access_stage_if.master         dmem,
  output logic                       mem_stall,
  output logic                       mem_misalign,
  output logic [31:0]                mem_alu_res,
  output logic [31:0]                mem_mem_data,
  output logic                       mem_wb_sel,
  output logic                       mem_wb_en,
  output logic [4:0]                 mem_rd
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;

  // Access attributes captured at issue, used when the ack returns
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic        store_r;
  logic [31:0] alu_res_r;
  logic        wb_sel_r;
  logic        wb_en_r;
  logic [4:0]  rd_r;

  logic        is_mem;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        trap;
  logic        start;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Decode the EX/MEM slot: alignment, issue condition, strobes and lane data
  always_comb begin
    is_mem     = ex_mem_rd_en | ex_mem_wr_en;
    is_half    = (ex_mem_size == 2'b01);
    is_word    = ex_mem_size[1];  // size 11 behaves as word
    misaligned = (is_half & ex_alu_res[0]) | (is_word & (ex_alu_res[1:0] != 2'b00));
    trap       = MISALIGN_TRAP & misaligned;
    start      = ex_valid & is_mem & ~trap;

    // Without trapping, misaligned low address bits are forced to alignment
    if (!MISALIGN_TRAP && is_word) begin
      off = 2'b00;
    end else if (!MISALIGN_TRAP && is_half) begin
      off = {ex_alu_res[1], 1'b0};
    end else begin
      off = ex_alu_res[1:0];
    end

    case (ex_mem_size)
      2'b00: begin
        strb  = 4'b0001 << off;
        wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << off;
        wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = ex_store_data;
      end
    endcase

    mem_stall = ((state == IDLE) & start) | ((state == WAIT) & ~dmem.dmem_ack);
  end

  // Align the returned word to the accessed lane and extend to 32 bits
  always_comb begin
    shifted = dmem.dmem_rdata >> {off_r, 3'b000};
    case (size_r)
      2'b00:   load_data = unsigned_r ? {24'h000000, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_r ? {16'h0000, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  // Access FSM with registered bus and MEM/WB outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wstrb <= 4'b0000;
      dmem.dmem_wdata <= 32'h0;
      mem_misalign    <= 1'b0;
      mem_alu_res     <= 32'h0;
      mem_mem_data    <= 32'h0;
      mem_wb_sel      <= 1'b0;
      mem_wb_en       <= 1'b0;
      mem_rd          <= 5'd0;
      off_r           <= 2'b00;
      size_r          <= 2'b00;
      unsigned_r      <= 1'b0;
      store_r         <= 1'b0;
      alu_res_r       <= 32'h0;
      wb_sel_r        <= 1'b0;
      wb_en_r         <= 1'b0;
      rd_r            <= 5'd0;
    end else begin
      // MEM/WB defaults to a bubble; branches below override it
      mem_misalign <= 1'b0;
      mem_alu_res  <= 32'h0;
      mem_mem_data <= 32'h0;
      mem_wb_sel   <= 1'b0;
      mem_wb_en    <= 1'b0;
      mem_rd       <= 5'd0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= WAIT;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= ex_mem_wr_en;
            dmem.dmem_addr  <= {ex_alu_res[31:2], 2'b00};
            dmem.dmem_wstrb <= strb;
            dmem.dmem_wdata <= wdata;
            off_r           <= off;
            size_r          <= ex_mem_size;
            unsigned_r      <= ex_mem_unsigned;
            store_r         <= ex_mem_wr_en;
            alu_res_r       <= ex_alu_res;
            wb_sel_r        <= ex_wb_sel;
            wb_en_r         <= ex_wb_en;
            rd_r            <= ex_rd;
          end else if (ex_valid && is_mem) begin
            // Only reachable when trapping: drop the access, flag it
            mem_misalign <= 1'b1;
          end else if (ex_valid) begin
            mem_alu_res <= ex_alu_res;
            mem_wb_sel  <= ex_wb_sel;
            mem_wb_en   <= ex_wb_en;
            mem_rd      <= ex_rd;
          end else begin
            mem_wb_en <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'h0;
            dmem.dmem_wstrb <= 4'b0000;
            dmem.dmem_wdata <= 32'h0;
            mem_alu_res     <= alu_res_r;
            mem_mem_data    <= store_r ? 32'h0 : load_data;
            mem_wb_sel      <= wb_sel_r;
            mem_wb_en       <= wb_en_r;
            mem_rd          <= rd_r;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage pipeline, sitting between the EX/MEM boundary and the write-back stage. It issues loads and stores on a single-outstanding req/ack data-memory bus, stalls the upstream pipeline until the access completes, and extracts and extends byte or halfword load data. It drives the registered MEM/WB signals: ALU result, memory data, write-back select, destination register and write enable.

## Interface
Parameters:
- MISALIGN_TRAP, default 1: 1 = misaligned access is dropped and flagged; 0 = address low bits are forced to alignment and the access proceeds.

Ports (clock and reset first):
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM slot holds a real instruction.
- ex_alu_res  in  32  ALU result; the effective address for loads and stores.
- ex_store_data  in  32  rs2 value for stores.
- ex_mem_rd_en, ex_mem_wr_en  in  1 each  load / store; both set is treated as a store.
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- ex_mem_unsigned  in  1  zero-extend loads (1) or sign-extend (0).
- ex_wb_sel, ex_wb_en  in  1 each; ex_rd  in  5  write-back controls, passed through.
- dmem_req  out  1  registered bus request.
- dmem_we  out  1  store.
- dmem_addr  out  32  word-aligned address, addr[1:0] = 0.
- dmem_wstrb  out  4  byte-lane strobes.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete; rdata valid the same cycle.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  combinational; hold EX/MEM and all earlier stages.
- mem_misalign  out  1  registered one-cycle exception pulse.
- mem_alu_res, mem_mem_data  out  32 each  MEM/WB registers.
- mem_wb_sel, mem_wb_en  out  1 each; mem_rd  out  5  MEM/WB registers.

## Operation
- FSM states:
  - IDLE to WAIT: when ex_valid, (rd_en or wr_en) and the access is aligned (or MISALIGN_TRAP = 0).
  - WAIT to IDLE: on dmem_ack.
- On IDLE to WAIT:
  - Latch the bus fields and the instruction's write-back controls.
  - Set dmem_req = 1 at that edge.
  - dmem_req, dmem_we, dmem_addr, dmem_wstrb and dmem_wdata stay stable until ack.
- Strobes:
  - Byte: 0001 << a[1:0].
  - Half: 0011 << a[1:0].
  - Word: 1111.
- Store data is replicated to lanes: byte ×4, half ×2, word as-is.
- Load extraction:
  - Shift = a[1:0]×8.
  - Byte: bits [7:0] of the shifted word, extended.
  - Half: bits [15:0] of the shifted word, extended.
  - Word: unmodified.
- Misaligned means a half access with a[0] = 1, or a word access with a[1:0] ≠ 0. With MISALIGN_TRAP = 1:
  - No bus request and no stall.
  - mem_misalign = 1 for one cycle.
  - The MEM/WB slot becomes a bubble (mem_wb_en = 0).
- Non-memory instruction: MEM/WB registers load ex_* in one cycle, mem_mem_data = 0, mem_wb_en = ex_wb_en & ex_valid.
- ex_valid = 0: a bubble is written (mem_wb_en = 0); the other fields are don't-care but are written to 0.
- mem_stall = (IDLE & start condition) | (WAIT & ~dmem_ack).
- While stalled, MEM/WB receives a bubble every cycle.
- On the ack edge, MEM/WB receives the latched instruction. mem_mem_data holds the extended load data, or 0 for a store.
- dmem_ack in IDLE is ignored.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata = 0; all mem_* outputs = 0; mem_misalign = 0.
- Reset mid-WAIT abandons the access. A late ack after reset is ignored.
- Non-memory latency: presented in cycle N, visible in MEM/WB in cycle N+1.
- Memory access, with the instruction presented in cycle N:
  - mem_stall = 1 in cycle N.
  - dmem_req = 1 from N+1.
  - Ack in cycle N+1+k makes mem_stall = 0 that cycle.
  - The result appears in MEM/WB at N+2+k.
- Minimum load-to-use is 2 cycles (k = 0).
- dmem_req drops on the edge after ack. Back-to-back accesses have one IDLE cycle between req pulses.
- The EX/MEM inputs hold the same instruction during the stall. The block must not re-trigger while in WAIT.

## Test plan
- ALU op, ex_alu_res = 0x1234_5678, rd = 5, wb_en = 1: next cycle mem_alu_res = 0x1234_5678, mem_rd = 5, mem_wb_en = 1, no stall.
- Signed byte load at 0x103, rdata = 0x80FF_0000, ack after 2 wait cycles:
  - dmem_addr = 0x100.
  - Stall for 3 cycles.
  - mem_mem_data = 0xFFFF_FF80, mem_wb_en = 1 once.
  - Unsigned variant gives 0x0000_0080.
- Half store 0xABCD at 0x202 with zero-wait ack: dmem_wstrb = 1100, dmem_wdata = 0xABCD_ABCD, dmem_we = 1, req high exactly one cycle.
- Word load at 0x006 with MISALIGN_TRAP = 1: mem_misalign pulses 1 cycle, dmem_req stays 0, mem_wb_en = 0. With MISALIGN_TRAP = 0: dmem_addr = 0x004, load completes normally.
- Reset asserted in WAIT, ack arriving 1 cycle after release: all outputs 0, state IDLE, ack ignored, no MEM/WB write.
- Two consecutive word loads with ack held high: two req pulses separated by one idle cycle, two correct results in order.
